// File: rtl/hyper_responder_model.sv
`default_nettype none
// ============================================================================
//  Module   : hyper_responder_model
//  Purpose  : HyperBus memory responder; oversamples the bus on clk_i and
//             serves register/memory bursts. Optional HYPER_RESP_WRAP_EN
//             enables 16-word wrapped bursts.
//  Revision : 1.0 - initial release
// ============================================================================
module hyper_responder_model #(
    parameter int          AddrWidth     = 10,
    parameter int          LatencyCycles = 6,
    parameter logic        FixedLatency  = 1'b1,
    parameter logic [15:0] IdValue       = 16'h0C81
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hyper_reset_ni,
    input  logic       hyper_cs_ni,
    input  logic       hyper_ck_i,
    input  logic       hyper_rwds_i,
    output logic       hyper_rwds_o,
    output logic       hyper_rwds_oe_o,
    input  logic [7:0] hyper_dq_i,
    output logic [7:0] hyper_dq_o,
    output logic       hyper_dq_oe_o
);

    function automatic logic [3:0] f_lat_enc(input int cycles);
        case (cycles)
            3:       f_lat_enc = 4'hE;
            4:       f_lat_enc = 4'hF;
            5:       f_lat_enc = 4'h0;
            7:       f_lat_enc = 4'h2;
            default: f_lat_enc = 4'h1;
        endcase
    endfunction

    function automatic logic [4:0] f_lat_cycles(input logic [3:0] enc);
        case (enc)
            4'h0:    f_lat_cycles = 5'd5;
            4'h2:    f_lat_cycles = 5'd7;
            4'hE:    f_lat_cycles = 5'd3;
            4'hF:    f_lat_cycles = 5'd4;
            default: f_lat_cycles = 5'd6;
        endcase
    endfunction

    localparam int          c_depth    = 1 << AddrWidth;
    localparam logic [3:0]  c_lat_enc  = f_lat_enc(LatencyCycles);
    localparam logic [15:0] c_cr0_rst  = {8'h00, c_lat_enc, FixedLatency, 3'b000};
    localparam logic [31:0] c_cr0_addr = 32'h0000_0800;
    localparam logic [31:0] c_id0_addr = 32'h0000_0000;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_ca   = 3'd1;
    localparam logic [2:0] c_st_lat  = 3'd2;
    localparam logic [2:0] c_st_rd   = 3'd3;
    localparam logic [2:0] c_st_wr   = 3'd4;
    localparam logic [2:0] c_st_hold = 3'd5;

    logic [2:0]  r_ck_sync;
    logic [2:0]  r_cs_sync;
    logic [1:0]  r_hrst_sync;
    logic [7:0]  r_dq_meta;
    logic [7:0]  r_dq_sync;
    logic        r_rwds_meta;
    logic        r_rwds_sync;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_ca;
    logic [31:0] r_addr;
    logic        r_is_read;
    logic        r_is_reg;
    logic [15:0] r_cr0;
    logic [7:0]  r_wr_hi;
    logic        r_wr_hi_mask;
    logic [7:0]  r_dq;
    logic        r_dq_oe;
    logic        r_rwds;
    logic        r_rwds_oe;
    logic [15:0] r_mem [c_depth];

    logic        w_ck_edge;
    logic        w_ck_rise;
    logic        w_ck_fall;
    logic        w_cs_high;
    logic        w_cs_fall;
    logic        w_bus_rst;
    logic        w_abort;
    logic        w_ca_last;
    logic        w_ca_reg_wr;
    logic [31:0] w_ca_addr;
    logic [4:0]  w_lat_cycles;
    logic [4:0]  w_lat_total;
    logic        w_lat_last;
    logic        w_beat_hi;
    logic        w_beat_lo;
    logic [31:0] w_addr_inc;
    logic [15:0] w_rd_word;
    logic        w_mem_we_hi;
    logic        w_mem_we_lo;

    // Index [1] is the synchronized sample, [2] the previous one for edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ck_sync   <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_hrst_sync <= 2'b00;
            r_dq_meta   <= 8'h00;
            r_dq_sync   <= 8'h00;
            r_rwds_meta <= 1'b0;
            r_rwds_sync <= 1'b0;
        end else begin
            r_ck_sync   <= {r_ck_sync[1:0], hyper_ck_i};
            r_cs_sync   <= {r_cs_sync[1:0], hyper_cs_ni};
            r_hrst_sync <= {r_hrst_sync[0], hyper_reset_ni};
            r_dq_meta   <= hyper_dq_i;
            r_dq_sync   <= r_dq_meta;
            r_rwds_meta <= hyper_rwds_i;
            r_rwds_sync <= r_rwds_meta;
        end
    end

    assign w_ck_edge    = r_ck_sync[1] ^ r_ck_sync[2];
    assign w_ck_rise    = w_ck_edge & r_ck_sync[1];
    assign w_ck_fall    = w_ck_edge & ~r_ck_sync[1];
    assign w_cs_high    = r_cs_sync[1];
    assign w_cs_fall    = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_bus_rst    = ~r_hrst_sync[1];
    assign w_abort      = w_cs_high | w_bus_rst;

    // r_ca holds CA[47:16]; the last CA byte contributes only CA[2:0].
    assign w_ca_last    = (r_state == c_st_ca) & w_ck_edge & (r_cnt == 5'd5);
    assign w_ca_addr    = {r_ca[28:0], r_dq_sync[2:0]};
    assign w_ca_reg_wr  = ~r_ca[31] & r_ca[30];

    assign w_lat_cycles = f_lat_cycles(r_cr0[7:4]);
    assign w_lat_total  = r_cr0[3] ? {w_lat_cycles[3:0], 1'b0} : w_lat_cycles;
    assign w_lat_last   = (r_state == c_st_lat) & w_ck_rise & (r_cnt == w_lat_total - 5'd1);

    // The final latency rising edge doubles as the first data edge.
    assign w_beat_hi    = ~w_abort & w_ck_rise &
                          (w_lat_last | (r_state == c_st_rd) | (r_state == c_st_wr));
    assign w_beat_lo    = ~w_abort & w_ck_fall &
                          ((r_state == c_st_rd) | (r_state == c_st_wr));

`ifdef HYPER_RESP_WRAP_EN
    logic r_linear;
    assign w_addr_inc = r_linear ? (r_addr + 32'd1) : {r_addr[31:4], r_addr[3:0] + 4'd1};
`else
    logic w_unused_lin;
    assign w_unused_lin = r_ca[29];
    assign w_addr_inc   = r_addr + 32'd1;
`endif

    always_comb begin
        w_rd_word = r_mem[r_addr[AddrWidth-1:0]];
        if (r_is_reg) begin
            if (r_addr == c_id0_addr) begin
                w_rd_word = IdValue;
            end else if (r_addr == c_cr0_addr) begin
                w_rd_word = r_cr0;
            end else begin
                w_rd_word = 16'h0000;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (w_cs_fall) w_state_nxt = c_st_ca;
                c_st_ca:   if (w_ca_last) w_state_nxt = w_ca_reg_wr ? c_st_wr : c_st_lat;
                c_st_lat:  if (w_lat_last) w_state_nxt = r_is_read ? c_st_rd : c_st_wr;
                c_st_wr:   if (w_beat_lo & r_is_reg) w_state_nxt = c_st_hold;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= 5'd0;
            r_ca         <= 32'h0;
            r_addr       <= 32'h0;
            r_is_read    <= 1'b0;
            r_is_reg     <= 1'b0;
            r_cr0        <= c_cr0_rst;
            r_wr_hi      <= 8'h00;
            r_wr_hi_mask <= 1'b0;
            r_dq         <= 8'h00;
            r_dq_oe      <= 1'b0;
            r_rwds       <= 1'b0;
            r_rwds_oe    <= 1'b0;
`ifdef HYPER_RESP_WRAP_EN
            r_linear     <= 1'b1;
`endif
        end else begin
            if (w_bus_rst) begin
                r_cr0 <= c_cr0_rst;
            end else if (w_beat_lo & ~r_is_read & r_is_reg & (r_addr == c_cr0_addr)) begin
                r_cr0 <= {r_wr_hi, r_dq_sync};
            end

            if (w_abort) begin
                r_dq      <= 8'h00;
                r_dq_oe   <= 1'b0;
                r_rwds    <= 1'b0;
                r_rwds_oe <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_cs_fall) begin
                            r_cnt     <= 5'd0;
                            r_rwds_oe <= 1'b1;
                            r_rwds    <= r_cr0[3];
                        end
                    end
                    c_st_ca: begin
                        if (w_ck_edge) begin
                            r_cnt <= r_cnt + 5'd1;
                            if (r_cnt < 5'd4) r_ca <= {r_ca[23:0], r_dq_sync};
                            if (w_ca_last) begin
                                r_cnt     <= 5'd0;
                                r_is_read <= r_ca[31];
                                r_is_reg  <= r_ca[30];
                                r_addr    <= w_ca_addr;
                                r_rwds_oe <= 1'b0;
                                r_rwds    <= 1'b0;
`ifdef HYPER_RESP_WRAP_EN
                                r_linear  <= r_ca[29];
`endif
                            end
                        end
                    end
                    c_st_lat: begin
                        if (w_ck_rise) r_cnt <= r_cnt + 5'd1;
                    end
                    default: ;
                endcase

                if (w_beat_hi) begin
                    if (r_is_read) begin
                        r_dq      <= w_rd_word[15:8];
                        r_rwds    <= 1'b1;
                        r_dq_oe   <= 1'b1;
                        r_rwds_oe <= 1'b1;
                    end else begin
                        r_wr_hi      <= r_dq_sync;
                        r_wr_hi_mask <= r_rwds_sync;
                    end
                end

                if (w_beat_lo) begin
                    if (r_is_read) begin
                        r_dq   <= w_rd_word[7:0];
                        r_rwds <= 1'b0;
                    end
                    r_addr <= w_addr_inc;
                end
            end
        end
    end

    // Memory contents survive both resets; a word commits on its lower byte.
    assign w_mem_we_hi = w_beat_lo & ~r_is_read & ~r_is_reg & ~r_wr_hi_mask;
    assign w_mem_we_lo = w_beat_lo & ~r_is_read & ~r_is_reg & ~r_rwds_sync;

    always_ff @(posedge clk_i) begin
        if (w_mem_we_hi) r_mem[r_addr[AddrWidth-1:0]][15:8] <= r_wr_hi;
        if (w_mem_we_lo) r_mem[r_addr[AddrWidth-1:0]][7:0]  <= r_dq_sync;
    end

    assign hyper_dq_o      = r_dq;
    assign hyper_dq_oe_o   = r_dq_oe;
    assign hyper_rwds_o    = r_rwds;
    assign hyper_rwds_oe_o = r_rwds_oe;

endmodule
`default_nettype wire

// File: tb/tb_hyper_responder_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyper_responder_model
//  Purpose  : Directed bench for hyper_responder_model (HYPER_RESP_WRAP_EN
//             selects the expected wrapped-burst addresses).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hyper_responder_model;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       hyper_reset_ni = 1'b1;
    logic       hyper_cs_ni = 1'b1;
    logic       hyper_ck_i = 1'b0;
    logic       hyper_rwds_i = 1'b0;
    logic [7:0] hyper_dq_i = 8'h00;
    logic       hyper_rwds_o;
    logic       hyper_rwds_oe_o;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o;

    hyper_responder_model dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .hyper_reset_ni  (hyper_reset_ni),
        .hyper_cs_ni     (hyper_cs_ni),
        .hyper_ck_i      (hyper_ck_i),
        .hyper_rwds_i    (hyper_rwds_i),
        .hyper_rwds_o    (hyper_rwds_o),
        .hyper_rwds_oe_o (hyper_rwds_oe_o),
        .hyper_dq_i      (hyper_dq_i),
        .hyper_dq_o      (hyper_dq_o),
        .hyper_dq_oe_o   (hyper_dq_oe_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] wr_byte  [16];
    logic       wr_mask  [16];
    logic [7:0] obs_byte [16];
    logic       obs_strb [16];
    logic       obs_oe   [16];
    logic       obs_ca_rwds, obs_ca_oe, obs_pre_oe, obs_end_oe;
    logic [15:0] w;

    function automatic logic [47:0] make_ca(input logic rd, input logic rs,
                                            input logic lin, input logic [31:0] a);
        make_ca = {rd, rs, lin, a[31:3], 13'h0000, a[2:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // CK half period is 12 clk_i cycles; DQ/RWDS settle 4 cycles before each edge.
    task automatic ck_toggle();
        tick(4);
        hyper_ck_i = ~hyper_ck_i;
        tick(8);
    endtask

    task automatic bus_access(input logic [47:0] ca, input int lat,
                              input int nbytes, input logic is_rd);
        logic [47:0] sh;
        int npre;
        sh   = ca;
        npre = (lat > 0) ? (2 * lat - 2) : 0;
        @(negedge clk_i);
        hyper_cs_ni = 1'b0;
        hyper_ck_i  = 1'b0;
        tick(8);
        obs_ca_rwds = hyper_rwds_o;
        obs_ca_oe   = hyper_rwds_oe_o;
        for (int i = 0; i < 6; i++) begin
            hyper_dq_i = sh[47:40];
            sh = sh << 8;
            ck_toggle();
        end
        for (int i = 0; i < npre; i++) begin
            hyper_dq_i   = 8'h00;
            hyper_rwds_i = 1'b0;
            ck_toggle();
        end
        obs_pre_oe = hyper_dq_oe_o;
        for (int i = 0; i < nbytes; i++) begin
            hyper_dq_i   = is_rd ? 8'h00 : wr_byte[i];
            hyper_rwds_i = is_rd ? 1'b0 : wr_mask[i];
            ck_toggle();
            obs_byte[i] = hyper_dq_o;
            obs_strb[i] = hyper_rwds_o;
            obs_oe[i]   = hyper_dq_oe_o & hyper_rwds_oe_o;
        end
        @(negedge clk_i);
        hyper_cs_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 obs_end_oe = hyper_dq_oe_o | hyper_rwds_oe_o;
        hyper_rwds_i = 1'b0;
        tick(4);
        hyper_ck_i = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(4);
        rst_ni = 1'b1;
        tick(4);
        n_vec++; if (hyper_dq_o !== 8'h00) begin n_err++; $display("FAIL reset_dq: got %h want 00", hyper_dq_o); end
        n_vec++; if (hyper_dq_oe_o !== 1'b0) begin n_err++; $display("FAIL reset_dq_oe: got %b want 0", hyper_dq_oe_o); end
        n_vec++; if (hyper_rwds_o !== 1'b0) begin n_err++; $display("FAIL reset_rwds: got %b want 0", hyper_rwds_o); end
        n_vec++; if (hyper_rwds_oe_o !== 1'b0) begin n_err++; $display("FAIL reset_rwds_oe: got %b want 0", hyper_rwds_oe_o); end
        bus_access(make_ca(1'b1, 1'b1, 1'b1, 32'h800), 12, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'h0018) begin n_err++; $display("FAIL reset_cr0: got %h want 0018", w); end
        n_vec++; if (obs_ca_rwds !== 1'b1) begin n_err++; $display("FAIL reset_ca_rwds: got %b want 1", obs_ca_rwds); end
        n_vec++; if (obs_ca_oe !== 1'b1) begin n_err++; $display("FAIL reset_ca_rwds_oe: got %b want 1", obs_ca_oe); end
        bus_access(make_ca(1'b1, 1'b1, 1'b1, 32'h0), 12, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'h0C81) begin n_err++; $display("FAIL id0_read: got %h want 0c81", w); end
    endtask

    task automatic test_write_read();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        for (int j = 0; j < 4; j++) begin
            wr_byte[2*j] = exp_w[j][15:8]; wr_byte[2*j+1] = exp_w[j][7:0];
            wr_mask[2*j] = 1'b0;           wr_mask[2*j+1] = 1'b0;
        end
        bus_access(make_ca(1'b0, 1'b0, 1'b1, 32'h10), 12, 8, 1'b0);
        bus_access(make_ca(1'b1, 1'b0, 1'b1, 32'h10), 12, 8, 1'b1);
        n_vec++; if (obs_pre_oe !== 1'b0) begin n_err++; $display("FAIL wr_rd_early_data: dq_oe %b before 12th rise, want 0", obs_pre_oe); end
        for (int j = 0; j < 4; j++) begin
            w = {obs_byte[2*j], obs_byte[2*j+1]};
            n_vec++; if (w !== exp_w[j]) begin n_err++; $display("FAIL wr_rd_word%0d: got %h want %h", j, w, exp_w[j]); end
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_strb[i] !== ((i % 2) == 0) || obs_oe[i] !== 1'b1) begin
                n_err++; $display("FAIL wr_rd_strobe%0d: rwds %b oe %b want rwds %b oe 1", i, obs_strb[i], obs_oe[i], ((i % 2) == 0));
            end
        end
    endtask

    task automatic test_byte_mask();
        wr_byte[0] = 8'h12; wr_byte[1] = 8'h34; wr_mask[0] = 1'b0; wr_mask[1] = 1'b0;
        bus_access(make_ca(1'b0, 1'b0, 1'b1, 32'h40), 12, 2, 1'b0);
        wr_byte[0] = 8'hAB; wr_byte[1] = 8'hCD; wr_mask[0] = 1'b0; wr_mask[1] = 1'b1;
        bus_access(make_ca(1'b0, 1'b0, 1'b1, 32'h40), 12, 2, 1'b0);
        bus_access(make_ca(1'b1, 1'b0, 1'b1, 32'h40), 12, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'hAB34) begin n_err++; $display("FAIL byte_mask: got %h want ab34", w); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [4];
        wr_byte[0] = 8'h1E; wr_byte[1] = 8'h1E; wr_byte[2] = 8'h1F; wr_byte[3] = 8'h1F;
        wr_byte[4] = 8'h20; wr_byte[5] = 8'h20; wr_byte[6] = 8'h21; wr_byte[7] = 8'h21;
        for (int i = 0; i < 8; i++) wr_mask[i] = 1'b0;
        bus_access(make_ca(1'b0, 1'b0, 1'b1, 32'h1E), 12, 8, 1'b0);
        bus_access(make_ca(1'b1, 1'b0, 1'b0, 32'h1E), 12, 8, 1'b1);
        exp_w[0] = 16'h1E1E; exp_w[1] = 16'h1F1F;
`ifdef HYPER_RESP_WRAP_EN
        exp_w[2] = 16'h1111; exp_w[3] = 16'h2222;
`else
        exp_w[2] = 16'h2020; exp_w[3] = 16'h2121;
`endif
        for (int j = 0; j < 4; j++) begin
            w = {obs_byte[2*j], obs_byte[2*j+1]};
            n_vec++; if (w !== exp_w[j]) begin n_err++; $display("FAIL wrap_word%0d: got %h want %h", j, w, exp_w[j]); end
        end
    endtask

    task automatic test_abort();
        wr_byte[0] = 8'hAA; wr_byte[1] = 8'hAA; wr_byte[2] = 8'hBB; wr_byte[3] = 8'hBB;
        wr_byte[4] = 8'hCC; wr_byte[5] = 8'hCC;
        for (int i = 0; i < 6; i++) wr_mask[i] = 1'b0;
        bus_access(make_ca(1'b0, 1'b0, 1'b1, 32'h50), 12, 6, 1'b0);
        wr_byte[0] = 8'h11; wr_byte[1] = 8'h22; wr_byte[2] = 8'h33;
        bus_access(make_ca(1'b0, 1'b0, 1'b1, 32'h50), 12, 3, 1'b0);
        bus_access(make_ca(1'b1, 1'b0, 1'b1, 32'h50), 12, 3, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'h1122) begin n_err++; $display("FAIL abort_first_word: got %h want 1122", w); end
        n_vec++; if (obs_byte[2] !== 8'hBB) begin n_err++; $display("FAIL abort_target_word: got %h want bb", obs_byte[2]); end
        n_vec++; if (obs_oe[2] !== 1'b1) begin n_err++; $display("FAIL abort_oe_active: got %b want 1", obs_oe[2]); end
        n_vec++; if (obs_end_oe !== 1'b0) begin n_err++; $display("FAIL abort_oe_release: got %b want 0", obs_end_oe); end
        bus_access(make_ca(1'b1, 1'b0, 1'b1, 32'h51), 12, 4, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'hBBBB) begin n_err++; $display("FAIL abort_next_word0: got %h want bbbb", w); end
        w = {obs_byte[2], obs_byte[3]};
        n_vec++; if (w !== 16'hCCCC) begin n_err++; $display("FAIL abort_next_word1: got %h want cccc", w); end
    endtask

    task automatic test_reg_write();
        wr_byte[0] = 8'h00; wr_byte[1] = 8'h10; wr_mask[0] = 1'b0; wr_mask[1] = 1'b0;
        bus_access(make_ca(1'b0, 1'b1, 1'b1, 32'h800), 0, 2, 1'b0);
        bus_access(make_ca(1'b1, 1'b1, 1'b1, 32'h800), 6, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'h0010) begin n_err++; $display("FAIL regwr_cr0: got %h want 0010", w); end
        n_vec++; if (obs_ca_rwds !== 1'b0) begin n_err++; $display("FAIL regwr_ca_rwds: got %b want 0", obs_ca_rwds); end
        n_vec++; if (obs_pre_oe !== 1'b0) begin n_err++; $display("FAIL regwr_early_data: got %b want 0", obs_pre_oe); end
        n_vec++; if (obs_oe[0] !== 1'b1) begin n_err++; $display("FAIL regwr_lat6_data: oe %b want 1", obs_oe[0]); end
        bus_access(make_ca(1'b1, 1'b0, 1'b1, 32'h10), 6, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'h1111) begin n_err++; $display("FAIL regwr_mem_lat6: got %h want 1111", w); end
    endtask

    task automatic test_bus_reset();
        @(negedge clk_i);
        hyper_reset_ni = 1'b0;
        tick(6);
        hyper_reset_ni = 1'b1;
        tick(6);
        bus_access(make_ca(1'b1, 1'b1, 1'b1, 32'h800), 12, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'h0018) begin n_err++; $display("FAIL busrst_cr0: got %h want 0018", w); end
        n_vec++; if (obs_ca_rwds !== 1'b1) begin n_err++; $display("FAIL busrst_ca_rwds: got %b want 1", obs_ca_rwds); end
        bus_access(make_ca(1'b1, 1'b0, 1'b1, 32'h40), 12, 2, 1'b1);
        w = {obs_byte[0], obs_byte[1]};
        n_vec++; if (w !== 16'hAB34) begin n_err++; $display("FAIL busrst_mem_kept: got %h want ab34", w); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_wrap();
        test_abort();
        test_reg_write();
        test_bus_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
